// File: rtl/param_serial_sub_pkg.sv
// rtl/param_serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package param_serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/param_serial_sub_full_subtractor.sv
// rtl/param_serial_sub_full_subtractor.sv - 1-bit combinational full subtractor (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference bit and borrow out of a single bit position
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/param_serial_sub.sv
// rtl/param_serial_sub.sv - bit-serial LSB-first subtractor with start/done handshake; optional SERIAL_SUB_OVF_EN
module param_serial_sub
  import param_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic             start_pi,
  input  logic [WIDTH-1:0] A_pi,
  input  logic [WIDTH-1:0] B_pi,
  output logic             busy_po,
  output logic             done_po,
  output logic [WIDTH:0]   result_po
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_po
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_next;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             fs_d;
  logic             fs_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign busy_po = (state == SHIFT);

  // new difference bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  always_comb begin
    diff_next            = diff >> 1;
    diff_next[WIDTH-1]   = fs_d;
  end

  // state register
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: accept start only when idle, leave SHIFT after the last bit
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_pi) state_next = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // datapath: capture operands, shift one bit per cycle, publish result on the DONE edge
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      a_sr      <= '0;
      b_sr      <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      done_po   <= 1'b0;
      result_po <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ovf_po    <= 1'b0;
`endif
    end else begin
      done_po <= 1'b0;
      case (state)
        IDLE: begin
          if (start_pi) begin
            a_sr   <= A_pi;
            b_sr   <= B_pi;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= A_pi[WIDTH-1];
            b_msb  <= B_pi[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          borrow <= fs_bout;
          diff   <= diff_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          result_po <= {borrow, diff};
          done_po   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_po    <= (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
